// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg : shared AES-128 constants, round-constant and S-box helpers |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package aes_pkg;

    localparam int NK   = 4;
    localparam int NB   = 4;
    localparam int NR   = 10;
    localparam int RK_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } state_e;

    function automatic logic [31:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_key_step : one forward or inverse AES-128 key-schedule step      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] w_in,
    input  logic [31:0]  rc,
    input  logic         inv,
    output logic [127:0] w_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] sub_in, rot, sub, t;

    assign w0 = w_in[127:96];
    assign w1 = w_in[95:64];
    assign w2 = w_in[63:32];
    assign w3 = w_in[31:0];

    // The inverse step recovers the old w3 as w3^w2 before SubWord, so one S-box row serves both.
    assign sub_in = inv ? (w3 ^ w2) : w3;
    assign rot    = {sub_in[23:0], sub_in[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign sub[i*8 +: 8] = sbox(rot[i*8 +: 8]);
    end

    assign t = sub ^ rc;

    always_comb begin
        w_out = '0;
        if (inv) begin
            w_out[127:96] = w0 ^ t;
            w_out[95:64]  = w1 ^ w0;
            w_out[63:32]  = w2 ^ w1;
            w_out[31:0]   = w3 ^ w2;
        end else begin
            w_out[127:96] = w0 ^ t;
            w_out[95:64]  = w1 ^ w0 ^ t;
            w_out[63:32]  = w2 ^ w1 ^ w0 ^ t;
            w_out[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ t;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_inv_key_schedule.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_inv_key_schedule : AES-128 round keys 10..0 for decryption       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module aes_inv_key_schedule
    import aes_pkg::state_e, aes_pkg::IDLE, aes_pkg::EXPAND, aes_pkg::EMIT,
           aes_pkg::rcon, aes_pkg::RK_W;
#(
    parameter int NR = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [RK_W-1:0] key,
    output logic            busy,
    output logic            rk_valid,
    input  logic            rk_ready,
    output logic [RK_W-1:0] rk,
    output logic [3:0]      rk_round,
    output logic            rk_last,
    output logic            done
);

    state_e          state, state_n;
    logic [RK_W-1:0] cur, cur_n, step_out;
    logic [3:0]      rnd, rnd_n;
    logic            done_n;
    logic            step_inv;

    aes_key_step u_step (
        .w_in  (cur),
        .rc    (rcon(rnd)),
        .inv   (step_inv),
        .w_out (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cur   <= '0;
            rnd   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cur   <= cur_n;
            rnd   <= rnd_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        cur_n    = cur;
        rnd_n    = rnd;
        done_n   = 1'b0;
        step_inv = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cur_n   = key;
                    rnd_n   = 4'd1;
                    state_n = EXPAND;
                end
            end
            EXPAND: begin
                cur_n = step_out;
                if (rnd == 4'(NR)) begin
                    state_n = EMIT;
                end else begin
                    rnd_n = rnd + 4'd1;
                end
            end
            EMIT: begin
                // rcon(rnd) is the constant that produced key rnd, so it also undoes it.
                step_inv = 1'b1;
                if (rk_ready) begin
                    if (rnd != 4'd0) begin
                        cur_n = step_out;
                        rnd_n = rnd - 4'd1;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign rk_valid = (state == EMIT);
    assign rk       = rk_valid ? cur : '0;
    assign rk_round = rk_valid ? rnd : 4'd0;
    assign rk_last  = rk_valid && (rnd == 4'd0);

endmodule
`default_nettype wire

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
Sequential AES-128 round-key source for the decryption datapath.
- Accepts the cipher key and runs the forward schedule one round per clock to reach round key 10.
- Then streams round keys 10 down to 0 over a valid/ready handshake, recomputing each earlier key with the inverse schedule step, so no 11x128 key store is needed.
- Sits between the key input and the inverse-cipher round engine.

Parameters:
- NR, 10, number of rounds; fixed for AES-128 (Nk=4, Nb=4); other values unsupported.

Ports:
- clk       input   1    system clock, rising edge
- rst_n     input   1    asynchronous active-low reset
- start     input   1    load key and begin; sampled only in IDLE
- key       input   128  cipher key, word 0 in [127:96]
- busy      output  1    high in EXPAND and EMIT
- rk_valid  output  1    rk/rk_round/rk_last valid
- rk_ready  input   1    consumer accepts current round key
- rk        output  128  round key, word 0 in [127:96]
- rk_round  output  4    round index of rk (10..0)
- rk_last   output  1    high with rk_valid when rk_round==0
- done      output  1    one-cycle pulse after round 0 key accepted

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; cur and all outputs = 0; rnd=0.
- IDLE:
  - When start=1: cur<=key, rnd<=1, go to EXPAND.
  - start in any other state is ignored.
- EXPAND:
  - Each cycle: cur<=fwd_step(cur, rcon(rnd)).
  - If rnd==NR: rnd<=NR and go to EMIT. Otherwise rnd<=rnd+1.
  - Exactly NR cycles.
- EMIT:
  - rk_valid=1, rk=cur, rk_round=rnd, rk_last=(rnd==0).
  - On rk_valid&rk_ready with rnd>0: cur<=inv_step(cur, rcon(rnd)), rnd<=rnd-1.
  - On acceptance with rnd==0: go to IDLE, done=1 for one cycle, rk_valid drops the same cycle.
  - While rk_ready=0, rk/rk_round/rk_last are held stable and valid.
- Latency: start sampled at edge 0 -> rk_valid high after edge 10 (first valid cycle is cycle 11 counting the start cycle as 1).
  - With rk_ready tied high: 11 keys on consecutive cycles, then done.
  - Start-to-done = 21 cycles.
- fwd_step(w0..w3, rc):
  - t=SubWord(RotWord(w3))^rc
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2
- inv_step(w0..w3, rc):
  - p3=w3^w2, p2=w2^w1, p1=w1^w0
  - p0=w0^SubWord(RotWord(p3))^rc
- rcon(i): i=1..10 -> 01,02,04,08,10,20,40,80,1b,36 in the top byte, other bytes zero; any other index -> 0.
- busy=1 from the cycle after start through the cycle of final acceptance.
- Key change mid-operation has no effect; key is sampled only at start.
- rst_n low mid-EXPAND or mid-EMIT: immediate return to IDLE, rk_valid=0, no done pulse.
- start high in the same cycle as the final acceptance is ignored; a new start is needed in IDLE.

Decomposition:
- Package aes_pkg holds:
  - constants NK=4, NB=4, NR=10, RK_W=128
  - rcon table/function
  - sbox byte function (shared with the cipher cores)
  - state enum {IDLE, EXPAND, EMIT}
- Sub-module aes_key_step: purely combinational.
  - Inputs: w_in[127:0], rc[31:0], inv.
  - Output: w_out.
  - Shares one SubWord (4 S-boxes): the SubWord input is muxed between w3 (forward) and w3^w2 (inverse).
  - The FSM/counter wrapper instantiates it once.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1, start pulse:
  - rk_valid rises 10 cycles after the start edge.
  - First rk=d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_round=10.
  - Next rk=ac7766f319fadc2128d12941575c006e (round 9).
  - Round 1 rk=a0fafe1788542cb123a339392a6c7605.
  - Last rk=2b7e...4f3c with rk_last=1, then done for 1 cycle.
- All-zero key: first rk=b4ef5bcb3e92e21123e951cf6f8f188e (round 10); final rk=0 (round 0).
- Backpressure with random rk_ready (~30% high):
  - rk/rk_round are stable while rk_ready=0.
  - Sequence is identical to the first test.
  - No key skipped or duplicated (check via a scoreboard against the forward reference model).
- start pulsed again during EXPAND and during EMIT with a different key: ignored, output matches the original key.
- rst_n asserted at EMIT round 6: outputs go to 0 asynchronously. After release, a start with the FIPS key gives the full correct sequence.
- Back-to-back runs: start issued in the first IDLE cycle after done gives correct keys for the new key, with no stale rk_valid.
